// File: rtl/control.sv
// control: single-cycle instruction decoder producing datapath and bus control strobes.
// Define CONTROL_OUTREG_EN to register every output (one clock of latency, async reset).
`timescale 1ns/1ps

module control (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inst,
    input  logic       cycle,
    input  logic       carry,
    output logic       M,
    output logic       S,
    output logic       J,
    output logic       LJ,
    output logic       CLI,
    output logic       LJR,
    output logic       MW,
    output logic       MC,
    output logic       RD,
    output logic       WR,
    output logic       Y,
    output logic       WA,
    output logic       ISP,
    output logic       WC,
    output logic [1:0] RS,
    output logic [3:0] ALU,
    output logic [7:0] SIG
);

    typedef struct packed {
        logic       m;
        logic       s;
        logic       j;
        logic       lj;
        logic       cli;
        logic       ljr;
        logic       mw;
        logic       mc;
        logic       rd;
        logic       wr;
        logic       y;
        logic       wa;
        logic       isp;
        logic       wc;
        logic [1:0] rs;
        logic [3:0] alu;
        logic [7:0] sig;
    } decodeT;

    decodeT dec;
    decodeT outQ;

    logic i7, i6, i5, i4, i3, i2, i1;
    logic aTerm;
    logic ioGroup;
    logic sigOp;

    assign {i7, i6, i5, i4, i3, i2, i1} = inst[7:1];

    // ALU-class instruction, or its second cycle for the i6 group with i5 clear.
    assign aTerm   = (i6 & ~i7) | (cycle & i6 & ~i5);
    assign ioGroup = ~i7 & ~i6 & ~i5 & ~i4;
    assign sigOp   = ~i7 & ~i6 & ~i5 & i4 & i3;

    always_comb begin
        // NOTE: default the whole bundle first so no path through this block can infer a latch.
        dec = '0;

        dec.m   = i7 & ~i6 & cycle;
        dec.s   = i4;
        dec.j   = i7 & i6 & i5 & cycle & ~(carry & i4);
        dec.lj  = ~i7 & ~i6 & ~i5 & i4 & ~i3;
        dec.cli = dec.lj & i1;
        dec.ljr = dec.lj & i2;
        dec.mw  = dec.m & i5;
        dec.mc  = i7 & ~cycle;
        dec.rd  = ioGroup & i2;
        dec.wr  = ioGroup & i3;
        dec.y   = i5;
        dec.rs  = inst[1:0];
        dec.isp = ~i7 & ~i6 & i5;
        dec.wa  = (dec.m & ~i5) | (aTerm & ~(i4 & ~i3));
        dec.wc  = (aTerm | dec.isp) & i4;
        dec.alu = i6 ? inst[3:0] : {~i7, 3'b000};
        dec.sig = sigOp ? (8'd1 << inst[2:0]) : 8'h00;
    end

`ifdef CONTROL_OUTREG_EN
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            outQ <= '0;
        end else begin
            outQ <= dec;
        end
    end
`else
    logic unusedClkRst;

    assign outQ         = dec;
    assign unusedClkRst = clk ^ rst;
`endif

    assign {M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC, RS, ALU, SIG} = outQ;

endmodule

// File: tb/tb_control.sv
// tb_control: exhaustive, directed and random checks of control against a behavioural decode model.
// Build with +define+CONTROL_OUTREG_EN to exercise the registered-output variant.
`timescale 1ns/1ps

module tb_control;

    typedef struct packed {
        logic       m;
        logic       s;
        logic       j;
        logic       lj;
        logic       cli;
        logic       ljr;
        logic       mw;
        logic       mc;
        logic       rd;
        logic       wr;
        logic       y;
        logic       wa;
        logic       isp;
        logic       wc;
        logic [1:0] rs;
        logic [3:0] alu;
        logic [7:0] sig;
    } outT;

    logic       clk;
    logic       rst;
    logic [7:0] inst;
    logic       cycle;
    logic       carry;
    logic       M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC;
    logic [1:0] RS;
    logic [3:0] ALU;
    logic [7:0] SIG;

    outT act;
    outT held;
    bit  checkEn;
    int  checks;
    int  errors;

    control dut (
        .clk   (clk),
        .rst   (rst),
        .inst  (inst),
        .cycle (cycle),
        .carry (carry),
        .M     (M),
        .S     (S),
        .J     (J),
        .LJ    (LJ),
        .CLI   (CLI),
        .LJR   (LJR),
        .MW    (MW),
        .MC    (MC),
        .RD    (RD),
        .WR    (WR),
        .Y     (Y),
        .WA    (WA),
        .ISP   (ISP),
        .WC    (WC),
        .RS    (RS),
        .ALU   (ALU),
        .SIG   (SIG)
    );

    assign act = {M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC, RS, ALU, SIG};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode rules expressed as opcode-field tests rather than per-bit gate terms.
    function automatic outT model(input logic [7:0] i, input logic cyc, input logic cy);
        outT o;
        logic [2:0] top3;
        logic [4:0] top5;
        logic [1:0] top2;
        bit aluGroup;
        top3 = i[7:5];
        top5 = i[7:3];
        top2 = i[7:6];
        o = '0;
        o.s   = i[4];
        o.y   = i[5];
        o.rs  = i[1:0];
        o.m   = (top2 == 2'b10) && cyc;
        o.j   = (top3 == 3'b111) && cyc && !(cy && i[4]);
        o.lj  = (top5 == 5'b00010);
        o.cli = o.lj && i[1];
        o.ljr = o.lj && i[2];
        o.mw  = o.m && i[5];
        o.mc  = i[7] && !cyc;
        o.rd  = (i[7:4] == 4'h0) && i[2];
        o.wr  = (i[7:4] == 4'h0) && i[3];
        o.isp = (top3 == 3'b001);
        aluGroup = (top2 == 2'b01) || (cyc && i[6] && !i[5]);
        o.wa  = (o.m && !i[5]) || (aluGroup && (i[4:3] != 2'b10));
        o.wc  = (aluGroup || o.isp) && i[4];
        if (i[6])      o.alu = i[3:0];
        else if (i[7]) o.alu = 4'h0;
        else           o.alu = 4'h8;
        o.sig = (top5 == 5'b00011) ? (8'd1 << i[2:0]) : 8'h00;
        return o;
    endfunction

    task automatic checkOut(input string name, input outT got, input outT exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (inst=%h cycle=%b carry=%b rst=%b t=%0t)",
                     name, got, exp, inst, cycle, carry, rst, $time);
        end
    endtask

    // Single compare process: after each rising edge, and again after the inputs move mid-cycle.
    always begin
        @(posedge clk);
        #1;
        held = rst ? outT'('0) : model(inst, cycle, carry);
`ifdef CONTROL_OUTREG_EN
        if (checkEn) checkOut("cmpEdge", act, held);
`else
        if (checkEn) checkOut("cmpEdge", act, model(inst, cycle, carry));
`endif
        @(negedge clk);
        #2;
`ifdef CONTROL_OUTREG_EN
        if (checkEn) checkOut("cmpLatency", act, held);
`else
        if (checkEn) checkOut("cmpComb", act, model(inst, cycle, carry));
`endif
    end

    task automatic apply(input logic [7:0] i, input logic cyc, input logic cy);
        @(negedge clk);
        inst  = i;
        cycle = cyc;
        carry = cy;
        @(posedge clk);
        #3;
    endtask

    task automatic directed(input string name, input logic [7:0] i, input logic cyc,
                            input logic cy, input outT e);
        apply(i, cyc, cy);
        checkOut(name, act, e);
        checkOut({name, "Model"}, model(i, cyc, cy), e);
    endtask

    task automatic resetMidStream();
        checkEn = 1'b0;
        apply(8'hF0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
`ifdef CONTROL_OUTREG_EN
        checkOut("rstAsync", act, '0);
        @(negedge clk);
        inst = 8'h80;
        @(posedge clk);
        #2;
        checkOut("rstHold", act, '0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOut("rstRelease", act, '0);
        @(posedge clk);
        #2;
        checkOut("rstFirstEdge", act, model(inst, cycle, carry));
`else
        checkOut("rstNoEffect", act, model(inst, cycle, carry));
        inst = 8'h80;
        #1;
        checkOut("rstFollow", act, model(inst, cycle, carry));
        rst = 1'b0;
        @(posedge clk);
        #2;
`endif
        checkEn = 1'b1;
    endtask

    initial begin
        outT e;
        logic [9:0] v;
        checks  = 0;
        errors  = 0;
        checkEn = 1'b0;
        rst     = 1'b0;
        inst    = 8'h00;
        cycle   = 1'b0;
        carry   = 1'b0;
        #1;
        rst = 1'b1;
        #2;
`ifdef CONTROL_OUTREG_EN
        checkOut("resetState", act, '0);
`else
        checkOut("resetState", act, model(inst, cycle, carry));
`endif
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #2;
        checkEn = 1'b1;

        e = '0; e.m = 1; e.wa = 1;
        directed("memRead80", 8'h80, 1'b1, 1'b0, e);
        e = '0; e.j = 1; e.s = 1; e.y = 1;
        directed("jumpF0", 8'hF0, 1'b1, 1'b0, e);
        e = '0; e.s = 1; e.y = 1;
        directed("jumpF0Carry", 8'hF0, 1'b1, 1'b1, e);
        e = '0; e.lj = 1; e.cli = 1; e.ljr = 1; e.s = 1; e.rs = 2'b10; e.alu = 4'h8;
        directed("lj16", 8'h16, 1'b0, 1'b0, e);
        e = '0; e.s = 1; e.sig = 8'h20; e.rs = 2'b01; e.alu = 4'h8;
        directed("sig1D", 8'h1D, 1'b0, 1'b0, e);
        e = '0; e.rd = 1; e.wr = 1; e.alu = 4'h8;
        directed("io0C", 8'h0C, 1'b0, 1'b0, e);
        e = '0; e.wa = 1; e.alu = 4'hB; e.rs = 2'b11;
        directed("alu4B", 8'h4B, 1'b0, 1'b0, e);
        e = '0; e.mc = 1; e.y = 1;
        directed("memCycA0", 8'hA0, 1'b0, 1'b0, e);

        for (int n = 0; n < 1024; n++) begin
            v = 10'(n);
            apply(v[7:0], v[8], v[9]);
        end

        resetMidStream();

        for (int n = 0; n < 300; n++) begin
            apply(8'($urandom_range(255)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        resetMidStream();
        for (int n = 0; n < 20; n++) begin
            apply(8'($urandom_range(255)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        checkEn = 1'b0;
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 The block SHALL have clk, input, 1 bit: the single clock, used only when CONTROL_OUTREG_EN is defined.
REQ-002 The block SHALL have rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have inst, input, 8 bits: current instruction byte; i7..i0 below denote its bits.
REQ-004 The block SHALL have cycle, input, 1 bit: second-cycle flag of a two-cycle instruction.
REQ-005 The block SHALL have carry, input, 1 bit: current carry flag.
REQ-006 The block SHALL have the outputs M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP and WC, each 1 bit.
REQ-007 The block SHALL have the outputs RS (2 bits), ALU (4 bits) and SIG (8 bits).

Function
REQ-008 The decode SHALL be purely combinational, with no state, unless CONTROL_OUTREG_EN is defined.
REQ-009 M SHALL equal i7 & ~i6 & cycle.
REQ-010 S SHALL equal i4.
REQ-011 J SHALL equal i7 & i6 & i5 & cycle & ~(carry & i4); setting i4 suppresses the jump when carry=1.
REQ-012 LJ SHALL equal ~i7 & ~i6 & ~i5 & i4 & ~i3.
REQ-013 CLI SHALL equal LJ & i1.
REQ-014 LJR SHALL equal LJ & i2.
REQ-015 MW SHALL equal M & i5.
REQ-016 MC SHALL equal i7 & ~cycle.
REQ-017 RD SHALL equal ~i7 & ~i6 & ~i5 & ~i4 & i2.
REQ-018 WR SHALL equal ~i7 & ~i6 & ~i5 & ~i4 & i3.
REQ-019 Y SHALL equal i5.
REQ-020 RS SHALL equal inst[1:0].
REQ-021 The block SHALL form the internal term A = (i6 & ~i7) | (cycle & i6 & ~i5).
REQ-022 WA SHALL equal (M & ~i5) | (A & ~(i4 & ~i3)).
REQ-023 ISP SHALL equal ~i7 & ~i6 & i5.
REQ-024 WC SHALL equal (A | ISP) & i4.
REQ-025 ALU SHALL equal inst[3:0] when i6=1.
REQ-026 ALU SHALL equal {~i7, 3'b000} when i6=0.
REQ-027 SIG SHALL equal the one-hot value (1 << inst[2:0]) when ~i7 & ~i6 & ~i5 & i4 & i3 holds.
REQ-028 SIG SHALL be 8'h00 in every other case.
REQ-029 Every output SHALL be defined for all 1024 combinations of inst, cycle and carry; there are no don't-cares and no X outputs.

Reset
REQ-030 Without CONTROL_OUTREG_EN, rst SHALL have no effect on any output.
REQ-031 With CONTROL_OUTREG_EN, asserting rst SHALL asynchronously force every output to 0, including RS=2'b00, ALU=4'h0 and SIG=8'h00.
REQ-032 With CONTROL_OUTREG_EN, every output SHALL stay at 0 until the first rising edge of clk after rst is released.

Configuration
REQ-033 When the macro CONTROL_OUTREG_EN is undefined, all outputs SHALL follow the inputs combinationally with zero cycles of latency.
REQ-034 When CONTROL_OUTREG_EN is defined, every output SHALL be captured on the rising edge of clk, with exactly one clock of latency from inst, cycle and carry.
REQ-035 With CONTROL_OUTREG_EN defined, the registered values SHALL equal the combinational equations of REQ-009 to REQ-028 for the inputs sampled at that edge.

Verification
REQ-036 inst=0x80, cycle=1, carry=0 -> M=1, WA=1, MW=0, MC=0, ALU=4'h0; all other 1-bit outputs 0, RS=2'b00, SIG=8'h00.
REQ-037 inst=0xF0, cycle=1, carry=0 -> J=1, S=1, Y=1, ALU=4'h0, WA=0, WC=0; the same inputs with carry=1 -> J=0.
REQ-038 inst=0x16, cycle=0 -> LJ=1, CLI=1, LJR=1, S=1, RS=2'b10, ALU=4'h8, RD=0, SIG=8'h00.
REQ-039 inst=0x1D -> LJ=0, SIG=8'h20, RS=2'b01, ALU=4'h8; inst=0x0C -> RD=1, WR=1, ALU=4'h8.
REQ-040 inst=0x4B, cycle=0 -> WA=1, WC=0, ALU=4'hB, RS=2'b11; inst=0xA0, cycle=0 -> MC=1, Y=1, M=0.
REQ-041 An exhaustive sweep of all 1024 combinations of inst, cycle and carry SHALL be compared against a reference model of the equations.
REQ-042 With CONTROL_OUTREG_EN defined, the bench SHALL check the one-clock latency.
REQ-043 With CONTROL_OUTREG_EN defined, the bench SHALL assert rst mid-stream and check that all outputs go to 0 at once, without waiting for a clock edge.
